// File: rtl/mips_pipe_core_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_core_pkg
// Shared definitions for the five-stage MIPS subset pipeline:
//   - opcode / funct constants of the supported instructions
//   - ALU operation (aluop) and result-select (alusel) encodings
//   - the NOP word that fills empty pipeline slots
//   - decode_instr(): turns a 32-bit word into the ID-stage control record
// -----------------------------------------------------------------------------
package mips_pipe_core_pkg;

   localparam logic [5:0]  OP_SPECIAL = 6'h00;
   localparam logic [5:0]  OP_ANDI    = 6'h0C;
   localparam logic [5:0]  OP_ORI     = 6'h0D;
   localparam logic [5:0]  OP_XORI    = 6'h0E;
   localparam logic [5:0]  OP_LUI     = 6'h0F;

   localparam logic [5:0]  FN_ADDU    = 6'h21;
   localparam logic [5:0]  FN_SUBU    = 6'h23;
   localparam logic [5:0]  FN_AND     = 6'h24;
   localparam logic [5:0]  FN_OR      = 6'h25;
   localparam logic [5:0]  FN_XOR     = 6'h26;
   localparam logic [5:0]  FN_NOR     = 6'h27;

   localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
   localparam logic [4:0]  REG_ZERO   = 5'd0;
   localparam int          NUM_REGS   = 32;

   typedef enum logic [2:0] {
      ALU_NOP  = 3'd0,
      ALU_OR   = 3'd1,
      ALU_AND  = 3'd2,
      ALU_XOR  = 3'd3,
      ALU_NOR  = 3'd4,
      ALU_ADDU = 3'd5,
      ALU_SUBU = 3'd6
   } aluop_e;

   typedef enum logic [1:0] {
      SEL_NOP   = 2'd0,
      SEL_LOGIC = 2'd1,
      SEL_ARITH = 2'd2
   } alusel_e;

   // ID-stage control record
   typedef struct packed {
      logic       wreg;     // instruction writes a non-zero register
      logic [4:0] waddr;
      aluop_e     aluop;
      alusel_e    alusel;
      logic       use_rs;   // rs is a true source (hazard / forwarding)
      logic       use_rt;   // rt is a true source
      logic       imm_src;  // second operand comes from the immediate
      logic       is_lui;
   } dec_t;

   function automatic dec_t decode_instr(input logic [31:0] ins);
      dec_t d;
      d = '0;
      case (ins[31:26])
         OP_SPECIAL: begin
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
            d.waddr  = ins[15:11];
            case (ins[5:0])
               FN_OR:   begin d.aluop = ALU_OR;   d.alusel = SEL_LOGIC; end
               FN_AND:  begin d.aluop = ALU_AND;  d.alusel = SEL_LOGIC; end
               FN_XOR:  begin d.aluop = ALU_XOR;  d.alusel = SEL_LOGIC; end
               FN_NOR:  begin d.aluop = ALU_NOR;  d.alusel = SEL_LOGIC; end
               FN_ADDU: begin d.aluop = ALU_ADDU; d.alusel = SEL_ARITH; end
               FN_SUBU: begin d.aluop = ALU_SUBU; d.alusel = SEL_ARITH; end
               default: ;
            endcase
         end
         OP_ORI: begin
            d.use_rs = 1'b1; d.imm_src = 1'b1; d.waddr = ins[20:16];
            d.aluop  = ALU_OR;  d.alusel = SEL_LOGIC;
         end
         OP_ANDI: begin
            d.use_rs = 1'b1; d.imm_src = 1'b1; d.waddr = ins[20:16];
            d.aluop  = ALU_AND; d.alusel = SEL_LOGIC;
         end
         OP_XORI: begin
            d.use_rs = 1'b1; d.imm_src = 1'b1; d.waddr = ins[20:16];
            d.aluop  = ALU_XOR; d.alusel = SEL_LOGIC;
         end
         // LUI is OR of a zero first operand with the shifted immediate
         OP_LUI: begin
            d.imm_src = 1'b1; d.is_lui = 1'b1; d.waddr = ins[20:16];
            d.aluop   = ALU_OR; d.alusel = SEL_LOGIC;
         end
         default: ;
      endcase
      d.wreg = (d.alusel != SEL_NOP) && (d.waddr != REG_ZERO);
      // A word that writes nothing is a bubble: it must neither stall nor
      // carry a destination down the pipe.
      if (!d.wreg) begin
         d.use_rs = 1'b0;
         d.use_rt = 1'b0;
         d.waddr  = REG_ZERO;
      end
      return d;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
// 32-entry register file, 2 asynchronous read ports, 1 write port.
// Register 0 always reads 0 and ignores writes. A read of the register being
// written in the same cycle returns the write data (write-through).
// Ports:
//   clk, rst          clock, asynchronous active-low reset (clears all entries)
//   we_i/waddr_i/wdata_i   write port
//   raddrN_i/rdataN_o      read ports 1 and 2
// -----------------------------------------------------------------------------
module mips_regfile
   import mips_pipe_core_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [4:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic [4:0]        raddr2_i,
   output logic [DATA_W-1:0] rdata2_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != REG_ZERO)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = regs_q[raddr1_i];
      if (raddr1_i == REG_ZERO)                   rdata1_o = '0;
      else if (we_i && (waddr_i == raddr1_i))     rdata1_o = wdata_i;
   end

   always_comb begin
      rdata2_o = regs_q[raddr2_i];
      if (raddr2_i == REG_ZERO)                   rdata2_o = '0;
      else if (we_i && (waddr_i == raddr2_i))     rdata2_o = wdata_i;
   end

endmodule

// File: rtl/mips_pipe_core.sv
// -----------------------------------------------------------------------------
// mips_pipe_core
// Five-stage (IF/ID/EX/MEM/WB) in-order pipeline for a MIPS ALU subset
// (OR/AND/XOR/NOR/ADDU/SUBU, ORI/ANDI/XORI/LUI). Any other word is a bubble.
// RAW hazards are resolved by EX/MEM forwarding into ID (FWD_EN=1) or by
// stalling ID until the producer reaches WB (FWD_EN=0).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rom_data_i          instruction word for rom_addr_o (same cycle)
//   rom_rdy_i           ROM ready; word is taken when rom_ce_o & rom_rdy_i
//   rom_ce_o            ROM enable (0 in reset, 1 from the first edge after)
//   rom_addr_o          fetch address (PC)
//   wb_we_o/wb_waddr_o/wb_wdata_o   registered MEM/WB write-back
// -----------------------------------------------------------------------------
module mips_pipe_core
   import mips_pipe_core_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                FWD_EN   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       rom_data_i,
   input  logic              rom_rdy_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              wb_we_o,
   output logic [4:0]        wb_waddr_o,
   output logic [DATA_W-1:0] wb_wdata_o
);

   // IF
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ce_q;
   // IF/ID
   logic [31:0]       id_instr_q, id_instr_d;
   // ID/EX
   logic              ex_wreg_q;
   logic [4:0]        ex_waddr_q;
   aluop_e            ex_aluop_q;
   alusel_e           ex_alusel_q;
   logic [DATA_W-1:0] ex_op1_q, ex_op2_q;
   // EX/MEM
   logic              mem_wreg_q;
   logic [4:0]        mem_waddr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   // MEM/WB
   logic              wb_we_q;
   logic [4:0]        wb_waddr_q;
   logic [DATA_W-1:0] wb_wdata_q;

   // hazard / flow control
   logic              fetch_ok, raw_hit;
   logic              hold_pc, hold_ifid, flush_ifid, flush_idex;

   // ID stage
   dec_t              id_dec;
   logic [4:0]        id_rs, id_rt;
   logic [DATA_W-1:0] rf_rs, rf_rt, id_rs_val, id_rt_val, id_op1, id_op2;
   logic [DATA_W-1:0] ex_result;

   assign id_dec = decode_instr(id_instr_q);
   assign id_rs  = id_instr_q[25:21];
   assign id_rt  = id_instr_q[20:16];

   // Register file: WB stage writes, ID stage reads (write-through covers
   // the WB -> ID case in both forwarding modes).
   mips_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we_i     (wb_we_q),
      .waddr_i  (wb_waddr_q),
      .wdata_i  (wb_wdata_q),
      .raddr1_i (id_rs),
      .rdata1_o (rf_rs),
      .raddr2_i (id_rt),
      .rdata2_o (rf_rt)
   );

   // ------------------------------------------------------------------
   // Stall and bubble generation. A RAW stall beats a fetch miss: IF/ID
   // must keep the stalled instruction rather than take a bubble.
   // ------------------------------------------------------------------
   always_comb begin
      raw_hit    = 1'b0;
      fetch_ok   = ce_q && rom_rdy_i;
      if (FWD_EN == 0) begin
         raw_hit = (id_dec.use_rs && ((ex_wreg_q  && (ex_waddr_q  == id_rs)) ||
                                      (mem_wreg_q && (mem_waddr_q == id_rs)))) ||
                   (id_dec.use_rt && ((ex_wreg_q  && (ex_waddr_q  == id_rt)) ||
                                      (mem_wreg_q && (mem_waddr_q == id_rt))));
      end
      hold_pc    = raw_hit || !fetch_ok;
      hold_ifid  = raw_hit;
      flush_ifid = !raw_hit && !fetch_ok;
      flush_idex = raw_hit;
   end

   always_comb begin
      pc_d       = pc_q;
      id_instr_d = id_instr_q;
      if (!hold_pc)        pc_d       = pc_q + ADDR_W'(4);
      if (flush_ifid)      id_instr_d = NOP_WORD;
      else if (!hold_ifid) id_instr_d = rom_data_i;
   end

   // ID operand selection: youngest producer wins (EX, then MEM, then the
   // regfile read which already includes WB write-through). Register 0 can
   // never match because nothing with waddr 0 carries wreg.
   always_comb begin
      id_rs_val = rf_rs;
      id_rt_val = rf_rt;
      if (FWD_EN != 0) begin
         if (mem_wreg_q && (mem_waddr_q == id_rs)) id_rs_val = mem_wdata_q;
         if (ex_wreg_q  && (ex_waddr_q  == id_rs)) id_rs_val = ex_result;
         if (mem_wreg_q && (mem_waddr_q == id_rt)) id_rt_val = mem_wdata_q;
         if (ex_wreg_q  && (ex_waddr_q  == id_rt)) id_rt_val = ex_result;
      end
   end

   always_comb begin
      id_op1 = id_dec.use_rs ? id_rs_val : '0;
      id_op2 = id_rt_val;
      if (id_dec.imm_src) begin
         // zero-extended immediate; LUI places it at [31:16], truncated or
         // zero-padded to the datapath width
         id_op2 = id_dec.is_lui ? DATA_W'({id_instr_q[15:0], 16'h0000})
                                : DATA_W'(id_instr_q[15:0]);
      end
   end

   // EX stage ALU
   always_comb begin
      ex_result = '0;
      case (ex_alusel_q)
         SEL_LOGIC: begin
            case (ex_aluop_q)
               ALU_OR:  ex_result = ex_op1_q | ex_op2_q;
               ALU_AND: ex_result = ex_op1_q & ex_op2_q;
               ALU_XOR: ex_result = ex_op1_q ^ ex_op2_q;
               ALU_NOR: ex_result = ~(ex_op1_q | ex_op2_q);
               default: ex_result = '0;
            endcase
         end
         SEL_ARITH: begin
            case (ex_aluop_q)
               ALU_ADDU: ex_result = ex_op1_q + ex_op2_q;
               ALU_SUBU: ex_result = ex_op1_q - ex_op2_q;
               default:  ex_result = '0;
            endcase
         end
         default: ex_result = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         ce_q        <= 1'b0;
         id_instr_q  <= NOP_WORD;
         ex_wreg_q   <= 1'b0;
         ex_waddr_q  <= REG_ZERO;
         ex_aluop_q  <= ALU_NOP;
         ex_alusel_q <= SEL_NOP;
         ex_op1_q    <= '0;
         ex_op2_q    <= '0;
         mem_wreg_q  <= 1'b0;
         mem_waddr_q <= REG_ZERO;
         mem_wdata_q <= '0;
         wb_we_q     <= 1'b0;
         wb_waddr_q  <= REG_ZERO;
         wb_wdata_q  <= '0;
      end else begin
         ce_q       <= 1'b1;
         pc_q       <= pc_d;
         id_instr_q <= id_instr_d;

         if (flush_idex) begin
            ex_wreg_q   <= 1'b0;
            ex_waddr_q  <= REG_ZERO;
            ex_aluop_q  <= ALU_NOP;
            ex_alusel_q <= SEL_NOP;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
         end else begin
            ex_wreg_q   <= id_dec.wreg;
            ex_waddr_q  <= id_dec.waddr;
            ex_aluop_q  <= id_dec.aluop;
            ex_alusel_q <= id_dec.alusel;
            ex_op1_q    <= id_op1;
            ex_op2_q    <= id_op2;
         end

         mem_wreg_q  <= ex_wreg_q;
         mem_waddr_q <= ex_waddr_q;
         mem_wdata_q <= ex_result;

         wb_we_q     <= mem_wreg_q;
         wb_waddr_q  <= mem_waddr_q;
         wb_wdata_q  <= mem_wdata_q;
      end
   end

   assign rom_ce_o   = ce_q;
   assign rom_addr_o = pc_q;
   assign wb_we_o    = wb_we_q;
   assign wb_waddr_o = wb_waddr_q;
   assign wb_wdata_o = wb_wdata_q;

endmodule

// File: tb/tb_mips_pipe_core.sv
// -----------------------------------------------------------------------------
// tb_mips_pipe_core
// Two cores share one program ROM image: u_fwd (FWD_EN=1) and u_stl
// (FWD_EN=0). A table of instructions with hand-computed write-backs checks
// exact timing; hand sequences cover stall bubbles, fetch misses and a
// mid-stream reset; random programs are checked in program order against an
// instruction-level model.
// -----------------------------------------------------------------------------
module tb_mips_pipe_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic [31:0] prog [1024];

   logic        ce_f, we_f, ce_s, we_s;
   logic [31:0] addr_f, data_f, wdata_f, addr_s, data_s, wdata_s;
   logic [4:0]  waddr_f, waddr_s;

   assign data_f = prog[addr_f[11:2]];
   assign data_s = prog[addr_s[11:2]];

   mips_pipe_core #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .FWD_EN(1)) u_fwd (
      .clk(clk), .rst(rst), .rom_data_i(data_f), .rom_rdy_i(rdy),
      .rom_ce_o(ce_f), .rom_addr_o(addr_f),
      .wb_we_o(we_f), .wb_waddr_o(waddr_f), .wb_wdata_o(wdata_f));

   mips_pipe_core #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .FWD_EN(0)) u_stl (
      .clk(clk), .rst(rst), .rom_data_i(data_s), .rom_rdy_i(rdy),
      .rom_ce_o(ce_s), .rom_addr_o(addr_s),
      .wb_we_o(we_s), .wb_waddr_o(waddr_s), .wb_wdata_o(wdata_s));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [36:0] q_f[$], q_s[$], exp_q[$];

   // write-back monitor: collects every register write in order
   always @(negedge clk) begin
      if (rst) begin
         if (we_f) q_f.push_back({waddr_f, wdata_f});
         if (we_s) q_s.push_back({waddr_s, wdata_s});
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_q(input string name, input logic [36:0] got[$]);
      int n;
      check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({name, "_write"}, 64'(got[i]), 64'(exp_q[i]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Enter reset, clear collected writes, release; returns in cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      q_f.delete();
      q_s.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Instruction-level model: executes prog[0..n-1] one instruction at a time.
   function automatic void model_run(input int n);
      logic [31:0] r [32];
      logic [31:0] w, val;
      logic [4:0]  dst;
      bit          ok;
      for (int i = 0; i < 32; i++) r[i] = 32'h0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         w = prog[i]; ok = 1'b1; val = 32'h0;
         if (w[31:26] == 6'h00) begin
            dst = w[15:11];
            case (w[5:0])
               6'h25: val = r[w[25:21]] | r[w[20:16]];
               6'h24: val = r[w[25:21]] & r[w[20:16]];
               6'h26: val = r[w[25:21]] ^ r[w[20:16]];
               6'h27: val = ~(r[w[25:21]] | r[w[20:16]]);
               6'h21: val = r[w[25:21]] + r[w[20:16]];
               6'h23: val = r[w[25:21]] - r[w[20:16]];
               default: ok = 1'b0;
            endcase
         end else begin
            dst = w[20:16];
            case (w[31:26])
               6'h0D: val = r[w[25:21]] | {16'h0, w[15:0]};
               6'h0C: val = r[w[25:21]] & {16'h0, w[15:0]};
               6'h0E: val = r[w[25:21]] ^ {16'h0, w[15:0]};
               6'h0F: val = {w[15:0], 16'h0};
               default: ok = 1'b0;
            endcase
         end
         if (ok && dst != 5'd0) begin
            r[dst] = val;
            exp_q.push_back({dst, val});
         end
      end
   endfunction

   typedef struct {
      logic [31:0] ins;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;

   localparam int NV = 16;
   vec_t vt [NV];

   task automatic load_table();
      for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
      exp_q.delete();
      for (int i = 0; i < NV; i++) begin
         prog[i] = vt[i].ins;
         if (vt[i].we) exp_q.push_back({vt[i].wa, vt[i].wd});
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0]  ra, rb, rc;
      logic [15:0] imm;
      int          cyc;

      vt[0]  = '{itype(6'h0D, 5'd1, 5'd0, 16'h1100), 1'b1, 5'd1,  32'h0000_1100};
      vt[1]  = '{itype(6'h0D, 5'd2, 5'd1, 16'h0020), 1'b1, 5'd2,  32'h0000_1120};
      vt[2]  = '{rtype(6'h25, 5'd3, 5'd2, 5'd1),     1'b1, 5'd3,  32'h0000_1120};
      vt[3]  = '{itype(6'h0F, 5'd4, 5'd0, 16'hFFFF), 1'b1, 5'd4,  32'hFFFF_0000};
      vt[4]  = '{rtype(6'h21, 5'd5, 5'd4, 5'd4),     1'b1, 5'd5,  32'hFFFE_0000};
      vt[5]  = '{itype(6'h0D, 5'd0, 5'd0, 16'h0005), 1'b0, 5'd0,  32'h0};
      vt[6]  = '{rtype(6'h23, 5'd6, 5'd1, 5'd2),     1'b1, 5'd6,  32'hFFFF_FFE0};
      vt[7]  = '{rtype(6'h24, 5'd7, 5'd3, 5'd5),     1'b1, 5'd7,  32'h0000_0000};
      vt[8]  = '{rtype(6'h26, 5'd8, 5'd2, 5'd4),     1'b1, 5'd8,  32'hFFFF_1120};
      vt[9]  = '{rtype(6'h27, 5'd9, 5'd1, 5'd0),     1'b1, 5'd9,  32'hFFFF_EEFF};
      vt[10] = '{itype(6'h0C, 5'd10, 5'd8, 16'hF0F0),1'b1, 5'd10, 32'h0000_1020};
      vt[11] = '{itype(6'h0E, 5'd11, 5'd9, 16'hFFFF),1'b1, 5'd11, 32'hFFFF_1100};
      vt[12] = '{32'hFFFF_FFFF,                      1'b0, 5'd0,  32'h0};
      vt[13] = '{rtype(6'h21, 5'd12, 5'd6, 5'd2),    1'b1, 5'd12, 32'h0000_1100};
      vt[14] = '{32'h0000_0000,                      1'b0, 5'd0,  32'h0};
      vt[15] = '{rtype(6'h25, 5'd13, 5'd12, 5'd11),  1'b1, 5'd13, 32'hFFFF_1100};

      // ---------------- table: exact timing on the forwarding core -------
      load_table();
      rdy = 1'b1;
      #3;
      check("rst_ce",    64'(ce_f),    64'(0));
      check("rst_pc",    64'(addr_f),  64'(0));
      check("rst_we",    64'(we_f),    64'(0));
      check("rst_waddr", 64'(waddr_f), 64'(0));
      check("rst_wdata", 64'(wdata_f), 64'(0));
      check("rst_we_s",  64'(we_s),    64'(0));
      do_reset();
      check("c0_ce", 64'(ce_f),   64'(1));
      check("c0_pc", 64'(addr_f), 64'(0));
      for (int c = 1; c <= 70; c++) begin
         tick();
         if (c == 1) check("c1_pc", 64'(addr_f), 64'(4));
         if (c >= 4 && c - 4 < NV) begin
            check("tbl_we", 64'(we_f), 64'(vt[c-4].we));
            if (vt[c-4].we) begin
               check("tbl_waddr", 64'(waddr_f), 64'(vt[c-4].wa));
               check("tbl_wdata", 64'(wdata_f), 64'(vt[c-4].wd));
            end
         end
         // stalling core: writes at 4, 7, 10 with two bubbles between
         if (c >= 4 && c <= 10)
            check("stall_we", 64'(we_s), 64'((c == 4) || (c == 7) || (c == 10)));
         if (c == 10) check("stall_r3", 64'({waddr_s, wdata_s}), 64'({5'd3, 32'h1120}));
      end
      cmp_q("tbl_fwd", q_f);
      cmp_q("tbl_stl", q_s);

      // ---------------- fetch miss for 3 cycles ---------------------------
      load_table();
      do_reset();
      for (int c = 1; c <= 70; c++) begin
         rdy = !(c >= 4 && c <= 6);   // applies to cycle c-1..: set before edge
         if (c == 1) rdy = 1'b1;
         tick();
         // rdy was low in cycles 3,4,5
         if (c >= 3 && c <= 6) check("miss_pc_hold", 64'(addr_f), 64'(12));
         if (c == 7)           check("miss_pc_go",   64'(addr_f), 64'(16));
         if (c >= 7 && c <= 9) check("miss_bubble",  64'(we_f),   64'(0));
         if (c == 10) check("miss_r4", 64'({we_f, waddr_f, wdata_f}), 64'({1'b1, 5'd4, 32'hFFFF_0000}));
      end
      rdy = 1'b1;
      cmp_q("miss_fwd", q_f);
      cmp_q("miss_stl", q_s);

      // ---------------- mid-stream reset -----------------------------------
      load_table();
      do_reset();
      for (int c = 1; c <= 6; c++) tick();
      check("pre_rst_we", 64'(we_f), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      check("async_we_f", 64'(we_f),   64'(0));
      check("async_we_s", 64'(we_s),   64'(0));
      check("async_pc_f", 64'(addr_f), 64'(0));
      check("async_pc_s", 64'(addr_s), 64'(0));
      check("async_ce",   64'(ce_f),   64'(0));
      for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
      prog[0] = rtype(6'h25, 5'd6, 5'd1, 5'd0);   // OR $6,$1,$0 exposes $1
      do_reset();
      for (int c = 1; c <= 4; c++) tick();
      check("r1_clear_f", 64'({we_f, waddr_f, wdata_f}), 64'({1'b1, 5'd6, 32'h0}));
      check("r1_clear_s", 64'({we_s, waddr_s, wdata_s}), 64'({1'b1, 5'd6, 32'h0}));

      // ---------------- random programs vs model --------------------------
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
         for (int i = 0; i < 40; i++) begin
            ra  = 5'($urandom_range(0, 7));
            rb  = 5'($urandom_range(0, 7));
            rc  = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            case ($urandom_range(0, 11))
               0:  prog[i] = rtype(6'h25, ra, rb, rc);
               1:  prog[i] = rtype(6'h24, ra, rb, rc);
               2:  prog[i] = rtype(6'h26, ra, rb, rc);
               3:  prog[i] = rtype(6'h27, ra, rb, rc);
               4:  prog[i] = rtype(6'h21, ra, rb, rc);
               5:  prog[i] = rtype(6'h23, ra, rb, rc);
               6:  prog[i] = itype(6'h0D, ra, rb, imm);
               7:  prog[i] = itype(6'h0C, ra, rb, imm);
               8:  prog[i] = itype(6'h0E, ra, rb, imm);
               9:  prog[i] = itype(6'h0F, ra, rb, imm);
               10: prog[i] = {6'h23, 26'($urandom)};
               default: prog[i] = 32'h0;
            endcase
         end
         model_run(40);
         do_reset();
         cyc = 0;
         while ((q_f.size() < exp_q.size() || q_s.size() < exp_q.size()) && cyc < 600) begin
            rdy = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
         end
         rdy = 1'b1;
         cmp_q("rnd_fwd", q_f);
         cmp_q("rnd_stl", q_s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
